parking_hour_log: RTL and testbench

- Consumer of the work-day timing pulses: counts car entries per work hour during the day and stores one count per hour.
- When the work day ends, it plays the stored counts out over a valid/ready stream to the display/report logic.
- Sits downstream of the hour counter (work_hour, expired_one_hour, work_day_expired) and the entry-gate sensor.

---
 rtl/parking_hour_log_pkg.sv | 15 +
 rtl/parking_hour_log_if.sv | 17 +
 rtl/parking_hour_log_sat_counter.sv | 21 ++
 rtl/parking_hour_log.sv | 119 +++++++++++
 tb/tb_parking_hour_log.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/parking_hour_log_pkg.sv
// Shared types and defaults for the per-hour car entry log.
package parking_pkg;

   localparam int HOUR_W        = 4;
   localparam int MAX_HOURS_DEF = 9;
   localparam int CNT_W_DEF     = 8;
   localparam int TOT_W_DEF     = 12;

   typedef enum logic [1:0] {
      LOG  = 2'd0,
      DUMP = 2'd1,
      DONE = 2'd2
   } log_state_t;

endpackage

// File: rtl/parking_hour_log_if.sv
// Record stream from the hour log to the display/report logic.
interface parking_hour_log_if
   import parking_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   logic              rd_valid;
   logic              rd_ready;
   logic [HOUR_W-1:0] rd_hour;
   logic [CNT_W-1:0]  rd_count;
   logic              rd_last;

   modport master (output rd_valid, output rd_hour, output rd_count, output rd_last,
                   input  rd_ready);
   modport slave  (input  rd_valid, input  rd_hour, input  rd_count, input  rd_last,
                   output rd_ready);
endinterface

// File: rtl/parking_hour_log_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q;

   // count up until all ones, then hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         cnt_q <= '0;
      else if (clr_i)                  cnt_q <= '0;
      else if (inc_i && (cnt_q != '1)) cnt_q <= cnt_q + W'(1);
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/parking_hour_log.sv
// Logs car entries per work hour during the day, then plays the per-hour
// counts out as a valid/ready record stream once the day has ended.
module parking_hour_log
   import parking_pkg::*;
#(
   parameter int MAX_HOURS = MAX_HOURS_DEF,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int TOT_W     = TOT_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                car_enter,
   input  logic [HOUR_W-1:0]   work_hour,
   input  logic                expired_one_hour,
   input  logic                work_day_expired,
   parking_hour_log_if.master  rd,
   output logic [TOT_W-1:0]    day_total,
   output logic                done
);
   log_state_t        state_q, state_d;
   logic [HOUR_W-1:0] idx_q, idx_d;
   logic [HOUR_W-1:0] last_hour_q;
   logic              have_data_q;
   logic [CNT_W-1:0]  mem_q [MAX_HOURS];
   logic [CNT_W-1:0]  cur_cnt;
   logic [CNT_W-1:0]  close_val;
   logic              in_log, car_ok, hour_wr;

   // Once the day has ended, entries no longer count anywhere.
   assign in_log  = (state_q == LOG);
   assign car_ok  = in_log && car_enter && !work_day_expired;
   // Out-of-range hours still close (cur_cnt clears) but store nothing.
   assign hour_wr = in_log && expired_one_hour &&
                    ({1'b0, work_hour} < (HOUR_W+1)'(MAX_HOURS));

   // An entry on the closing cycle belongs to the closing hour.
   assign close_val = (car_ok && (cur_cnt != '1)) ? cur_cnt + CNT_W'(1) : cur_cnt;

   sat_counter #(.W(CNT_W)) u_cur_cnt (
      .clk   (clk),
      .rst   (reset),
      .clr_i (in_log && expired_one_hour),
      .inc_i (car_ok),
      .cnt_o (cur_cnt)
   );

   sat_counter #(.W(TOT_W)) u_day_total (
      .clk   (clk),
      .rst   (reset),
      .clr_i (1'b0),
      .inc_i (car_ok),
      .cnt_o (day_total)
   );

   // per-hour slot store and the bookkeeping of the highest hour written
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MAX_HOURS; i++) mem_q[i] <= '0;
         last_hour_q <= '0;
         have_data_q <= 1'b0;
      end else if (hour_wr) begin
         mem_q[work_hour] <= close_val;
         last_hour_q      <= work_hour;
         have_data_q      <= 1'b1;
      end
   end

   // state and playout index registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LOG;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // next-state: an hour closing on the same edge the day ends still counts as data
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         LOG: begin
            if (work_day_expired) begin
               if (have_data_q || hour_wr) begin
                  state_d = DUMP;
                  idx_d   = '0;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DUMP: begin
            if (rd.rd_ready) begin
               if (idx_q == last_hour_q) state_d = DONE;
               else                      idx_d   = idx_q + HOUR_W'(1);
            end
         end
         DONE:    state_d = DONE;
         default: state_d = LOG;
      endcase
   end

   // record outputs come straight from registered state, zero outside playout
   always_comb begin
      rd.rd_valid = 1'b0;
      rd.rd_hour  = '0;
      rd.rd_count = '0;
      rd.rd_last  = 1'b0;
      done        = (state_q == DONE);
      if (state_q == DUMP) begin
         rd.rd_valid = 1'b1;
         rd.rd_hour  = idx_q;
         rd.rd_count = mem_q[idx_q];
         rd.rd_last  = (idx_q == last_hour_q);
      end
   end
endmodule

// File: tb/tb_parking_hour_log.sv
// Directed bench: default-width log plus a narrow instance for saturation.
module tb_parking_hour_log;
   import parking_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              car_enter;
   logic [HOUR_W-1:0] work_hour;
   logic              expired_one_hour;
   logic              work_day_expired;
   logic              rd_ready;
   logic [11:0]       day_total;
   logic              done;
   logic [2:0]        s_day_total;
   logic              s_done;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   parking_hour_log_if #(.CNT_W(8)) rd0 ();
   parking_hour_log_if #(.CNT_W(2)) rd1 ();
   assign rd0.rd_ready = rd_ready;
   assign rd1.rd_ready = rd_ready;

   parking_hour_log u_dut (
      .clk              (clk),
      .reset            (reset),
      .car_enter        (car_enter),
      .work_hour        (work_hour),
      .expired_one_hour (expired_one_hour),
      .work_day_expired (work_day_expired),
      .rd               (rd0),
      .day_total        (day_total),
      .done             (done)
   );

   parking_hour_log #(.MAX_HOURS(9), .CNT_W(2), .TOT_W(3)) u_sat (
      .clk              (clk),
      .reset            (reset),
      .car_enter        (car_enter),
      .work_hour        (work_hour),
      .expired_one_hour (expired_one_hour),
      .work_day_expired (work_day_expired),
      .rd               (rd1),
      .day_total        (s_day_total),
      .done             (s_done)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; car_enter = 1'b0; expired_one_hour = 1'b0;
      work_day_expired = 1'b0; work_hour = '0; rd_ready = 1'b1;
      repeat (5) tick();
      check("rst rd_valid", 32'(rd0.rd_valid), 0);
      check("rst rd_hour",  32'(rd0.rd_hour),  0);
      check("rst rd_count", 32'(rd0.rd_count), 0);
      check("rst rd_last",  32'(rd0.rd_last),  0);
      check("rst day_total", 32'(day_total),   0);
      check("rst done",     32'(done),         0);
      reset = 1'b0;
      tick();
   endtask

   // one 25-cycle hour: n entries at its start, optional entry on the closing pulse
   task automatic run_hour(input int h, input int n, input bit coinc);
      work_hour = HOUR_W'(h);
      for (int c = 0; c < 25; c++) begin
         car_enter        = (c < n);
         expired_one_hour = (c == 24);
         if (c == 24) car_enter = coinc;
         tick();
      end
      car_enter = 1'b0; expired_one_hour = 1'b0;
   endtask

   task automatic end_day();
      work_day_expired = 1'b1;
      tick();
   endtask

   task automatic expect_rec(input int h, input int cnt, input bit last);
      check($sformatf("rec%0d valid", h), 32'(rd0.rd_valid), 1);
      check($sformatf("rec%0d hour",  h), 32'(rd0.rd_hour),  32'(h));
      check($sformatf("rec%0d count", h), 32'(rd0.rd_count), 32'(cnt));
      check($sformatf("rec%0d last",  h), 32'(rd0.rd_last),  32'(last));
      check($sformatf("rec%0d done",  h), 32'(done),         0);
      tick();
   endtask

   task automatic expect_done();
      check("end done",     32'(done),         1);
      check("end rd_valid", 32'(rd0.rd_valid), 0);
      check("end rd_last",  32'(rd0.rd_last),  0);
   endtask

   initial begin
      int cnt2 [8];
      cnt2 = '{3, 0, 1, 1, 1, 1, 1, 1};

      // reset state
      do_reset();

      // hour-by-hour playout over an 8-hour day
      for (int h = 0; h < 8; h++) run_hour(h, cnt2[h], 1'b0);
      end_day();
      check("day_total 8h", 32'(day_total), 9);
      for (int h = 0; h < 8; h++) expect_rec(h, cnt2[h], h == 7);
      expect_done();
      car_enter = 1'b1; tick(); car_enter = 1'b0;
      check("total frozen", 32'(day_total), 9);

      // entry coincident with hour close goes to the closing hour
      do_reset();
      run_hour(0, 2, 1'b1);
      run_hour(1, 0, 1'b0);
      end_day();
      expect_rec(0, 3, 1'b0);
      expect_rec(1, 0, 1'b1);
      expect_done();

      // backpressure on the hour-2 record
      do_reset();
      run_hour(0, 1, 1'b0);
      run_hour(1, 2, 1'b0);
      run_hour(2, 4, 1'b0);
      run_hour(3, 0, 1'b0);
      end_day();
      expect_rec(0, 1, 1'b0);
      expect_rec(1, 2, 1'b0);
      rd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("hold valid", 32'(rd0.rd_valid), 1);
         check("hold hour",  32'(rd0.rd_hour),  2);
         check("hold count", 32'(rd0.rd_count), 4);
         tick();
      end
      rd_ready = 1'b1;
      expect_rec(2, 4, 1'b0);
      expect_rec(3, 0, 1'b1);
      expect_done();

      // saturation on the narrow instance
      do_reset();
      run_hour(0, 5, 1'b0);
      check("sat total 5", 32'(s_day_total), 5);
      run_hour(1, 5, 1'b0);
      check("sat total 10", 32'(s_day_total), 7);
      check("wide total 10", 32'(day_total), 10);
      end_day();
      check("sat r0 hour",  32'(rd1.rd_hour),  0);
      check("sat r0 count", 32'(rd1.rd_count), 3);
      tick();
      check("sat r1 count", 32'(rd1.rd_count), 3);
      check("sat r1 last",  32'(rd1.rd_last),  1);
      tick();
      check("sat done",     32'(s_done), 1);

      // no hour ever closed: straight to done, no records
      do_reset();
      end_day();
      check("nodata done",  32'(done),         1);
      check("nodata valid", 32'(rd0.rd_valid), 0);

      // nine-hour day, reset part way through playout
      do_reset();
      for (int h = 0; h < 9; h++) run_hour(h, h + 1, 1'b0);
      end_day();
      check("day_total 9h", 32'(day_total), 45);
      for (int h = 0; h < 3; h++) expect_rec(h, h + 1, 1'b0);
      reset = 1'b1;
      #1;
      check("async rd_valid", 32'(rd0.rd_valid), 0);
      check("async day_total", 32'(day_total),   0);
      tick();
      reset = 1'b0; work_day_expired = 1'b0;
      tick();
      check("post rst done", 32'(done), 0);
      run_hour(2, 1, 1'b0);
      end_day();
      expect_rec(0, 0, 1'b0);
      expect_rec(1, 0, 1'b0);
      expect_rec(2, 1, 1'b1);
      expect_done();

      // full nine-hour playout with last on hour 8
      do_reset();
      for (int h = 0; h < 9; h++) run_hour(h, 1, 1'b0);
      end_day();
      for (int h = 0; h < 9; h++) expect_rec(h, 1, h == 8);
      expect_done();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
